// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the wide load/store engine
package lsu_pkg;

  // Width of the byte counters (done/remaining/beat sizes); holds up to 15 bytes.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    LS_SIZE_8    = 2'd0,
    LS_SIZE_16   = 2'd1,
    LS_SIZE_32   = 2'd2,
    LS_SIZE_RSVD = 2'd3
  } ls_size_e;

  typedef enum logic [1:0] {
    LS_IDLE   = 2'd0,
    LS_ACCESS = 2'd1,
    LS_DONE   = 2'd2
  } ls_state_e;

  // Transfer length in bytes; 4-byte requests fall back to 1 byte on a 2-byte MDR,
  // and the reserved code is treated as a byte access.
  function automatic logic [CNT_W-1:0] size_to_bytes(input ls_size_e sz, input int max_bytes);
    case (sz)
      LS_SIZE_16: return CNT_W'(2);
      LS_SIZE_32: return (max_bytes == 4) ? CNT_W'(4) : CNT_W'(1);
      default:    return CNT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// rtl/ls_lane_align.sv - maps MDR bytes to/from bus byte lanes for one beat
module ls_lane_align
  import lsu_pkg::*;
#(
  parameter int BUS_BYTES = 2,
  parameter int MAX_BYTES = 4,
  parameter int LANE_W    = 1
) (
  input  logic [LANE_W-1:0]      lane,
  input  logic [CNT_W-1:0]       done,
  input  logic [CNT_W-1:0]       beat_bytes,
  input  logic [MAX_BYTES*8-1:0] mdr,
  input  logic [BUS_BYTES*8-1:0] rd_data,
  output logic [BUS_BYTES-1:0]   bytesel,
  output logic [BUS_BYTES*8-1:0] wr_data,
  output logic [MAX_BYTES-1:0]   mdr_be,
  output logic [MAX_BYTES*8-1:0] mdr_rd_data
);

  int rel_l;
  int idx_l;
  int rel_m;
  int src_m;

  // Bus side: lane i carries MDR byte done+(i-lane) when it falls inside the beat.
  always_comb begin
    bytesel = '0;
    wr_data = '0;
    rel_l   = 0;
    idx_l   = 0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      rel_l = i - int'(lane);
      idx_l = int'(done) + rel_l;
      if (rel_l >= 0 && rel_l < int'(beat_bytes)) begin
        bytesel[i] = 1'b1;
        if (idx_l < MAX_BYTES) begin
          wr_data[i*8 +: 8] = mdr[idx_l*8 +: 8];
        end
      end
    end
  end

  // MDR side: byte j is written from lane lane+(j-done) when it falls inside the beat.
  always_comb begin
    mdr_be      = '0;
    mdr_rd_data = '0;
    rel_m       = 0;
    src_m       = 0;
    for (int j = 0; j < MAX_BYTES; j++) begin
      rel_m = j - int'(done);
      src_m = int'(lane) + rel_m;
      if (rel_m >= 0 && rel_m < int'(beat_bytes)) begin
        mdr_be[j] = 1'b1;
        if (src_m < BUS_BYTES) begin
          mdr_rd_data[j*8 +: 8] = rd_data[src_m*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/load_store_wide.sv
// rtl/load_store_wide.sv - segmented load/store engine splitting transfers into bus beats
module load_store_wide
  import lsu_pkg::*;
#(
  parameter int BUS_BYTES  = 2,
  parameter int MAX_BYTES  = 4,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    write_mar,
  input  logic [15:0]                             mar_in,
  output logic [15:0]                             mar_out,
  input  logic [15:0]                             segment,
  input  logic                                    write_mdr,
  input  logic [MAX_BYTES*8-1:0]                  mdr_in,
  output logic [MAX_BYTES*8-1:0]                  mdr_out,
  input  logic                                    start,
  input  logic [1:0]                              size,
  input  logic                                    wr_en,
  output logic                                    busy,
  output logic                                    complete,
  output logic [ADDR_WIDTH-$clog2(BUS_BYTES)-1:0] m_addr,
  input  logic [BUS_BYTES*8-1:0]                  m_data_in,
  output logic [BUS_BYTES*8-1:0]                  m_data_out,
  output logic                                    m_access,
  input  logic                                    m_ack,
  output logic                                    m_wr_en,
  output logic [BUS_BYTES-1:0]                    m_bytesel
);

  localparam int LANE_W = $clog2(BUS_BYTES);
  localparam int MDR_W  = MAX_BYTES * 8;
  localparam int BUS_W  = BUS_BYTES * 8;

  ls_state_e              state;
  ls_state_e              next_state;
  logic [15:0]            mar;
  logic [MDR_W-1:0]       mdr;
  logic [CNT_W-1:0]       done;
  logic [CNT_W-1:0]       remaining;
  logic                   wr_q;

  logic [15:0]            off;
  logic [ADDR_WIDTH-1:0]  phys;
  logic [LANE_W-1:0]      lane;
  logic [CNT_W-1:0]       lane_room;
  logic [CNT_W-1:0]       beat_bytes;
  logic [CNT_W-1:0]       beat_active;
  logic                   last_beat;
  logic [BUS_W-1:0]       wr_data;
  logic [MAX_BYTES-1:0]   mdr_be;
  logic [MDR_W-1:0]       mdr_rd_data;

  // Offset wraps inside the segment; the physical address wraps at ADDR_WIDTH.
  assign off         = mar + {{(16-CNT_W){1'b0}}, done};
  assign phys        = ADDR_WIDTH'({segment, 4'b0000}) + ADDR_WIDTH'(off);
  assign lane        = phys[LANE_W-1:0];
  assign lane_room   = CNT_W'(BUS_BYTES) - CNT_W'(lane);
  assign beat_bytes  = (remaining < lane_room) ? remaining : lane_room;
  assign beat_active = (state == LS_ACCESS) ? beat_bytes : '0;
  assign last_beat   = (remaining == beat_bytes);

  assign m_addr     = phys[ADDR_WIDTH-1:LANE_W];
  assign m_data_out = wr_q ? wr_data : '0;
  assign mar_out    = mar;
  assign mdr_out    = mdr;

  ls_lane_align #(
    .BUS_BYTES (BUS_BYTES),
    .MAX_BYTES (MAX_BYTES),
    .LANE_W    (LANE_W)
  ) u_align (
    .lane        (lane),
    .done        (done),
    .beat_bytes  (beat_active),
    .mdr         (mdr),
    .rd_data     (m_data_in),
    .bytesel     (m_bytesel),
    .wr_data     (wr_data),
    .mdr_be      (mdr_be),
    .mdr_rd_data (mdr_rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LS_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus handshake outputs; the request drops in the ack cycle.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    complete   = 1'b0;
    m_access   = 1'b0;
    m_wr_en    = 1'b0;
    case (state)
      LS_IDLE: begin
        if (start) begin
          next_state = LS_ACCESS;
        end
      end
      LS_ACCESS: begin
        busy     = 1'b1;
        m_access = ~m_ack;
        m_wr_en  = wr_q;
        if (m_ack && last_beat) begin
          next_state = LS_DONE;
        end
      end
      LS_DONE: begin
        busy       = 1'b1;
        complete   = 1'b1;
        next_state = LS_IDLE;
      end
      default: begin
        next_state = LS_IDLE;
      end
    endcase
  end

  // MAR/MDR, transfer bookkeeping and read-data assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar       <= '0;
      mdr       <= '0;
      done      <= '0;
      remaining <= '0;
      wr_q      <= 1'b0;
    end else begin
      case (state)
        LS_IDLE: begin
          if (start) begin
            wr_q      <= wr_en;
            done      <= '0;
            remaining <= size_to_bytes(ls_size_e'(size), MAX_BYTES);
            if (!wr_en) begin
              mdr <= '0;
            end
          end else begin
            if (write_mar) begin
              mar <= mar_in;
            end
            if (write_mdr) begin
              mdr <= mdr_in;
            end
          end
        end
        LS_ACCESS: begin
          if (m_ack) begin
            if (!wr_q) begin
              for (int j = 0; j < MAX_BYTES; j++) begin
                if (mdr_be[j]) begin
                  mdr[j*8 +: 8] <= mdr_rd_data[j*8 +: 8];
                end
              end
            end
            if (!last_beat) begin
              done      <= done + beat_bytes;
              remaining <= remaining - beat_bytes;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_wide.sv
// tb/tb_load_store_wide.sv - randomized self-checking bench for load_store_wide
module tb_load_store_wide;

  localparam int BB = 2;
  localparam int MB = 4;
  localparam int AW = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_mar;
  logic [15:0] mar_in;
  logic [15:0] mar_out;
  logic [15:0] segment;
  logic        write_mdr;
  logic [31:0] mdr_in;
  logic [31:0] mdr_out;
  logic        start;
  logic [1:0]  size;
  logic        wr_en;
  logic        busy;
  logic        complete;
  logic [18:0] m_addr;
  logic [15:0] m_data_in;
  logic [15:0] m_data_out;
  logic        m_access;
  logic        m_ack;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;

  always #5 clk = ~clk;

  load_store_wide #(.BUS_BYTES(BB), .MAX_BYTES(MB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .write_mar(write_mar), .mar_in(mar_in), .mar_out(mar_out),
    .segment(segment), .write_mdr(write_mdr), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .start(start), .size(size), .wr_en(wr_en), .busy(busy), .complete(complete),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out), .m_access(m_access),
    .m_ack(m_ack), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected outputs for the current cycle, set by the stimulus.
  bit          chk_en = 0;
  logic        e_busy, e_complete, e_access, e_wr, e_inacc;
  logic [18:0] e_addr;
  logic [1:0]  e_sel;
  logic [15:0] e_dout;
  logic [15:0] e_mar;
  logic [31:0] e_mdr;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, e_busy);
      check("complete", complete, e_complete);
      check("m_access", m_access, e_access);
      check("m_wr_en", m_wr_en, e_wr);
      check("m_bytesel", m_bytesel, e_sel);
      check("m_data_out", m_data_out, e_dout);
      check("mar_out", mar_out, e_mar);
      check("mdr_out", mdr_out, e_mdr);
      if (e_inacc) check("m_addr", m_addr, e_addr);
    end
  end

  // Byte-level model: walk the transfer byte by byte and group bytes sharing a bus word.
  int          nb;
  logic [18:0] b_addr[3];
  logic [1:0]  b_sel[3];
  logic [15:0] b_dout[3];
  int          byte_beat[4];
  int          byte_lane[4];

  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      2'd1: return 2;
      2'd2: return 4;
      default: return 1;
    endcase
  endfunction

  task automatic build_beats(input logic [15:0] seg, input logic [15:0] mar,
                             input logic [1:0] sz, input logic [31:0] wdata);
    int          n;
    logic [15:0] off;
    logic [31:0] phys;
    logic [18:0] wa;
    int          ln;
    n  = size_bytes(sz);
    nb = 0;
    for (int k = 0; k < n; k++) begin
      off  = 16'(mar + 16'(k));
      phys = ((32'(seg) << 4) + 32'(off)) & 32'h000F_FFFF;
      wa   = phys[19:1];
      ln   = int'(phys[0]);
      if (nb == 0 || wa != b_addr[nb-1]) begin
        b_addr[nb] = wa;
        b_sel[nb]  = 2'b00;
        b_dout[nb] = 16'h0000;
        nb++;
      end
      b_sel[nb-1][ln]         = 1'b1;
      b_dout[nb-1][ln*8 +: 8] = wdata[k*8 +: 8];
      byte_beat[k] = nb - 1;
      byte_lane[k] = ln;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_busy = 0; e_complete = 0; e_access = 0; e_wr = 0; e_inacc = 0;
    e_sel = 2'b00; e_dout = 16'h0000;
  endtask

  task automatic garble_busy_inputs();
    start     = ($urandom_range(0, 3) == 0);
    size      = 2'($urandom);
    wr_en     = 1'($urandom);
    write_mar = 1'($urandom);
    mar_in    = 16'($urandom);
    write_mdr = 1'($urandom);
    mdr_in    = $urandom;
  endtask

  task automatic run_xfer(input logic [15:0] seg, input logic [15:0] mar, input logic [1:0] sz,
                          input logic wr, input logic [31:0] wdata, input bit fixed,
                          input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                          input bit clash, input int abort_beat);
    logic [15:0] dat[3];
    logic [15:0] rd;
    int          n;
    dat[0] = d0; dat[1] = d1; dat[2] = d2;
    n = size_bytes(sz);
    build_beats(seg, mar, sz, wdata);
    // load MAR and MDR
    write_mar = 1; mar_in = mar; write_mdr = 1; mdr_in = wdata;
    set_idle();
    tick();
    e_mar = mar; e_mdr = wdata;
    write_mar = 0; write_mdr = 0;
    segment = seg; size = sz; wr_en = wr; start = 1;
    if (clash) begin
      write_mar = 1; mar_in = ~mar; write_mdr = 1; mdr_in = ~wdata;
    end
    set_idle();
    tick();
    start = 0; write_mar = 0; write_mdr = 0;
    if (!wr) e_mdr = 32'h0;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_beat) begin
        reset = 1;
        set_idle();
        e_mar = 16'h0; e_mdr = 32'h0;
        tick();
        reset = 0;
        start = 0; write_mar = 0; write_mdr = 0; m_ack = 0;
        tick();
        return;
      end
      e_busy = 1; e_complete = 0; e_wr = wr; e_inacc = 1;
      e_addr = b_addr[b]; e_sel = b_sel[b]; e_dout = wr ? b_dout[b] : 16'h0;
      repeat ($urandom_range(0, 2)) begin
        m_ack = 0; m_data_in = 16'($urandom);
        garble_busy_inputs();
        e_access = 1;
        tick();
      end
      rd = fixed ? dat[b] : 16'($urandom);
      m_ack = 1; m_data_in = rd;
      garble_busy_inputs();
      e_access = 0;
      tick();
      m_ack = 0;
      if (!wr) begin
        for (int k = 0; k < n; k++)
          if (byte_beat[k] == b) e_mdr[k*8 +: 8] = rd[byte_lane[k]*8 +: 8];
      end
    end
    // completion cycle: stray ack and start must be ignored
    set_idle();
    e_busy = 1; e_complete = 1;
    garble_busy_inputs();
    m_ack = 1'($urandom); m_data_in = 16'($urandom);
    tick();
    start = 0; write_mar = 0; write_mdr = 0; m_ack = 0;
    set_idle();
  endtask

  initial begin
    logic [15:0] rs, rm;
    logic [1:0]  rz;
    reset = 1; write_mar = 0; mar_in = 0; segment = 0; write_mdr = 0; mdr_in = 0;
    start = 0; size = 0; wr_en = 0; m_data_in = 0; m_ack = 0;
    set_idle();
    e_mar = 16'h0; e_mdr = 32'h0; e_addr = '0;
    @(posedge clk); #1;
    chk_en = 1;
    tick();
    check("rst_mar_lit", mar_out, 32'h0);
    check("rst_mdr_lit", mdr_out, 32'h0);
    reset = 0;
    tick();

    // aligned word load
    build_beats(16'h1000, 16'h0010, 2'd1, 32'h0);
    check("pin1_nb", nb, 1);
    check("pin1_addr", b_addr[0], 19'h08008);
    check("pin1_sel", b_sel[0], 2'b11);
    run_xfer(16'h1000, 16'h0010, 2'd1, 0, 32'h5555AAAA, 1, 16'hBEEF, 0, 0, 0, -1);
    check("tp1_mdr_lit", mdr_out, 32'h0000BEEF);

    // unaligned word store
    build_beats(16'h1000, 16'h0011, 2'd1, 32'h1234);
    check("pin2_nb", nb, 2);
    check("pin2_addr0", b_addr[0], 19'h08008);
    check("pin2_addr1", b_addr[1], 19'h08009);
    check("pin2_sel0", b_sel[0], 2'b10);
    check("pin2_sel1", b_sel[1], 2'b01);
    check("pin2_dout0", b_dout[0], 16'h3400);
    check("pin2_dout1", b_dout[1], 16'h0012);
    run_xfer(16'h1000, 16'h0011, 2'd1, 1, 32'h1234, 0, 0, 0, 0, 0, -1);
    check("tp2_mdr_lit", mdr_out, 32'h00001234);

    // unaligned dword load
    build_beats(16'h1000, 16'h0003, 2'd2, 32'h0);
    check("pin3_nb", nb, 3);
    check("pin3_addr0", b_addr[0], 19'h08001);
    check("pin3_addr1", b_addr[1], 19'h08002);
    check("pin3_addr2", b_addr[2], 19'h08003);
    check("pin3_sel0", b_sel[0], 2'b10);
    check("pin3_sel1", b_sel[1], 2'b11);
    check("pin3_sel2", b_sel[2], 2'b01);
    run_xfer(16'h1000, 16'h0003, 2'd2, 0, 32'h0, 1, 16'hAA00, 16'hCCBB, 16'h00DD, 1, -1);
    check("tp3_mdr_lit", mdr_out, 32'hDDCCBBAA);

    // segment-offset wrap
    build_beats(16'h2000, 16'hFFFF, 2'd1, 32'h0);
    check("pin4_addr0", b_addr[0], 19'h17FFF);
    check("pin4_addr1", b_addr[1], 19'h10000);
    check("pin4_sel0", b_sel[0], 2'b10);
    check("pin4_sel1", b_sel[1], 2'b01);
    run_xfer(16'h2000, 16'hFFFF, 2'd1, 0, 32'h0, 0, 0, 0, 0, 0, -1);

    // 20-bit physical wrap
    build_beats(16'hFFFF, 16'h0010, 2'd0, 32'h0);
    check("pin5_addr", b_addr[0], 19'h00000);
    check("pin5_sel", b_sel[0], 2'b01);
    run_xfer(16'hFFFF, 16'h0010, 2'd0, 0, 32'hFFFFFFFF, 1, 16'h1277, 0, 0, 0, -1);
    check("tp5_mdr_lit", mdr_out, 32'h00000077);

    // abort between beats, then a fresh transfer
    run_xfer(16'h1000, 16'h0003, 2'd2, 0, 32'h0, 1, 16'h1100, 16'h3322, 16'h0044, 0, 1);
    check("tp6_abort_mdr_lit", mdr_out, 32'h0);
    run_xfer(16'h1000, 16'h0003, 2'd2, 0, 32'h0, 1, 16'h1100, 16'h3322, 16'h0044, 0, -1);
    check("tp6_fresh_mdr_lit", mdr_out, 32'h44332211);

    // randomized transfers
    for (int t = 0; t < 80; t++) begin
      rs = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      rm = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      rz = 2'($urandom);
      run_xfer(rs, rm, rz, 1'($urandom), $urandom, 0, 0, 0, 0, 1'($urandom),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
